// File: rtl/fmap_collector.sv
// fmap_collector
//   Captures one OUT_SIZE x OUT_SIZE conv output map (raster order) into an
//   internal buffer and re-streams it on request as a valid/ready raster
//   stream. Decouples gappy conv output timing from downstream backpressure.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   ce                clock enable; low freezes all state and outputs
//   conv_dout[N]      conv sample, written when conv_dout_vld is high
//   conv_dout_vld     conv sample valid
//   conv_dout_end     conv idle level; a rising edge mid-frame = short frame
//   rd_start          begin draining a held frame (pulse or level)
//   rd_ready          downstream ready
//   rd_dout[N]        registered read data
//   rd_vld, rd_last   read valid / final sample of the frame
//   full              a complete frame is held and not yet drained
//   done              one-cycle pulse after the last sample is accepted
//   err               sticky: overflow (sample while full/draining) or short frame
module fmap_collector #(
  parameter  int N        = 8,
  parameter  int OUT_SIZE = 4,
  localparam int DEPTH    = OUT_SIZE * OUT_SIZE
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic [N-1:0] conv_dout,
  input  logic         conv_dout_vld,
  input  logic         conv_dout_end,
  input  logic         rd_start,
  input  logic         rd_ready,
  output logic [N-1:0] rd_dout,
  output logic         rd_vld,
  output logic         rd_last,
  output logic         full,
  output logic         done,
  output logic         err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, FILL, FULL, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wr_cnt, rd_cnt, rd_nxt;
  logic [N-1:0]  mem [DEPTH];
  logic          end_q, end_rise;
  logic          wr_en, short_frame, ovf, rd_go, xfer;

  assign end_rise = conv_dout_end & ~end_q;
  assign rd_nxt   = rd_cnt + CW'(1);

  // Next state and per-cycle actions
  always_comb begin
    state_d     = state_q;
    wr_en       = 1'b0;
    short_frame = 1'b0;
    ovf         = 1'b0;
    rd_go       = 1'b0;
    xfer        = 1'b0;
    case (state_q)
      IDLE: begin
        if (conv_dout_vld) begin
          wr_en   = 1'b1;
          state_d = (DEPTH == 1) ? FULL : FILL;
        end
      end
      FILL: begin
        // A write that completes the frame wins over a coincident end edge;
        // otherwise the end edge aborts the frame and drops any sample.
        if (conv_dout_vld && wr_cnt == LAST) begin
          wr_en   = 1'b1;
          state_d = FULL;
        end else if (end_rise) begin
          short_frame = 1'b1;
          state_d     = IDLE;
        end else if (conv_dout_vld) begin
          wr_en = 1'b1;
        end
      end
      FULL: begin
        ovf = conv_dout_vld;
        if (rd_start) begin
          rd_go   = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        ovf = conv_dout_vld;
        if (rd_vld && rd_ready) begin
          xfer = 1'b1;
          if (rd_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      rd_dout <= '0;
      rd_vld  <= 1'b0;
      rd_last <= 1'b0;
      full    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      end_q   <= 1'b1;   // no spurious end edge right after reset
    end else if (ce) begin
      state_q <= state_d;
      end_q   <= conv_dout_end;
      done    <= 1'b0;
      if (wr_en)                  wr_cnt <= wr_cnt + CW'(1);
      if (wr_en && wr_cnt == LAST) full  <= 1'b1;
      if (short_frame) begin
        wr_cnt <= '0;
        err    <= 1'b1;
      end
      if (ovf) err <= 1'b1;
      if (rd_go) begin
        rd_cnt  <= '0;
        rd_dout <= mem[0];
        rd_vld  <= 1'b1;
        rd_last <= (DEPTH == 1);
      end
      if (xfer) begin
        if (rd_last) begin
          rd_vld  <= 1'b0;
          rd_last <= 1'b0;
          full    <= 1'b0;
          done    <= 1'b1;
          wr_cnt  <= '0;
        end else begin
          // Prefetch the next sample so a continuous ready gives 1 sample/cycle
          rd_cnt  <= rd_nxt;
          rd_dout <= mem[rd_nxt[AW-1:0]];
          rd_last <= (rd_nxt == LAST);
        end
      end
    end
  end

  // Frame buffer: synchronous write, contents survive reset
  always_ff @(posedge clk) begin
    if (rst_n && ce && wr_en) mem[wr_cnt[AW-1:0]] <= conv_dout;
  end

endmodule

// File: tb/tb_fmap_collector.sv
module tb_fmap_collector;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce = 1'b1;
  logic [7:0] conv_dout = '0;
  logic       conv_dout_vld = 1'b0;
  logic       conv_dout_end = 1'b0;
  logic       rd_start = 1'b0;
  logic       rd_ready = 1'b0;
  logic [7:0] rd_dout;
  logic       rd_vld, rd_last, full, done, err;

  int pass_cnt = 0;
  int total = 0;

  fmap_collector #(.N(8), .OUT_SIZE(4)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .conv_dout(conv_dout), .conv_dout_vld(conv_dout_vld), .conv_dout_end(conv_dout_end),
    .rd_start(rd_start), .rd_ready(rd_ready),
    .rd_dout(rd_dout), .rd_vld(rd_vld), .rd_last(rd_last),
    .full(full), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic send(input logic [7:0] v, input int gap);
    conv_dout     = v;
    conv_dout_vld = 1'b1;
    tick;
    conv_dout_vld = 1'b0;
    repeat (gap) tick;
  endtask

  task automatic fill(input int base, input int n);
    for (int i = 0; i < n; i++) send(8'(base + i), i % 4);
  endtask

  // Start a drain and accept n samples; bp randomizes rd_ready; frz >= 0
  // freezes ce for 5 cycles once frz samples have been accepted.
  task automatic drain(input bit bp, input int base, input int n, input int frz);
    int         idx = 0;
    int         cyc = 0;
    bit         stall = 1'b0;
    bit         frozen = 1'b0;
    logic [7:0] held = '0;
    rd_start = 1'b1;
    tick;
    rd_start = 1'b0;
    chk("latency_vld", 32'(rd_vld), 32'd1);
    while (idx < n && cyc < 400) begin
      if (stall) chk("hold", 32'({rd_vld, rd_dout}), 32'({1'b1, held}));
      if (!frozen && idx == frz) begin
        frozen   = 1'b1;
        held     = rd_dout;
        ce       = 1'b0;
        rd_ready = 1'b1;
        repeat (5) begin
          tick;
          chk("frz_drain", 32'({rd_vld, rd_dout}), 32'({1'b1, held}));
        end
        ce = 1'b1;
      end
      rd_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      stall    = rd_vld && !rd_ready;
      held     = rd_dout;
      if (rd_vld && rd_ready) begin
        chk("rd_dout", 32'(rd_dout), 32'(base + idx));
        chk("rd_last", 32'(rd_last), 32'(idx == 15));
        idx++;
      end
      tick;
      cyc++;
    end
    rd_ready = 1'b0;
    if (idx < n) chk("drain_timeout", 32'(idx), 32'(n));
    if (n == 16) begin
      chk("done_pulse", 32'({done, rd_vld, full}), 32'b100);
      tick;
      chk("done_clear", 32'(done), 32'd0);
    end
  endtask

  initial begin
    // Reset state
    tick; tick;
    chk("rst_outs", 32'({rd_vld, rd_last, full, done, err}), 32'd0);
    chk("rst_dout", 32'(rd_dout), 32'd0);
    rst_n = 1'b1;
    tick;

    // Basic frame
    fill(1, 15);
    chk("full_before", 32'(full), 32'd0);
    send(8'd16, 0);
    chk("full_after", 32'(full), 32'd1);
    drain(1'b0, 1, 16, -1);
    chk("basic_err", 32'(err), 32'd0);

    // Backpressure
    fill(1, 16);
    drain(1'b1, 1, 16, -1);
    chk("bp_err", 32'(err), 32'd0);

    // Overflow: 17th sample dropped, err set
    fill(1, 16);
    chk("ovf_err_pre", 32'(err), 32'd0);
    send(8'd17, 1);
    chk("ovf_err", 32'({err, full}), 32'b11);
    drain(1'b0, 1, 16, -1);

    // Short frame (reset first so err starts clear)
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("sf_err_pre", 32'(err), 32'd0);
    fill(51, 10);
    conv_dout_end = 1'b0;
    tick;
    conv_dout_end = 1'b1;
    tick;
    conv_dout_end = 1'b0;
    chk("sf_err", 32'({err, full}), 32'b10);
    rd_start = 1'b1;
    tick;
    rd_start = 1'b0;
    rd_ready = 1'b1;
    chk("sf_no_vld", 32'(rd_vld), 32'd0);
    tick;
    chk("sf_no_vld2", 32'(rd_vld), 32'd0);
    rd_ready = 1'b0;
    fill(21, 16);
    chk("sf_full", 32'(full), 32'd1);
    drain(1'b0, 21, 16, -1);

    // ce freeze mid-FILL and mid-DRAIN
    fill(41, 8);
    ce            = 1'b0;
    conv_dout     = 8'hEE;
    conv_dout_vld = 1'b1;
    repeat (5) tick;
    ce            = 1'b1;
    conv_dout_vld = 1'b0;
    chk("frz_fill_full", 32'(full), 32'd0);
    for (int i = 8; i < 16; i++) send(8'(41 + i), 0);
    chk("frz_full", 32'(full), 32'd1);
    drain(1'b0, 41, 16, 5);

    // Reset mid-drain
    fill(61, 16);
    drain(1'b0, 61, 6, -1);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("rst_mid", 32'({rd_vld, full, err, done}), 32'd0);
    tick;
    chk("rst_mid_nodone", 32'({rd_vld, done}), 32'd0);
    fill(101, 16);
    drain(1'b0, 101, 16, -1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/fmap_collector.md
Name: fmap_collector

Overview:
- Sink for the conv output stream (conv_dout / conv_dout_vld / conv_dout_end); captures one OUT_SIZE x OUT_SIZE output feature map in raster order into an internal buffer.
- Re-streams the map on request as a valid/ready raster stream to the next layer (pooling, FC or next conv).
- Sits between the conv unit and the downstream consumer.
- Decouples conv output timing, which is gappy and stride-dependent, from downstream backpressure.

Parameters:
- N, 8, data bit width of conv output and read stream.
- OUT_SIZE, 4, side length of the output map; conv INPUT_SIZE-KERNEL_SIZE+1 for stride 1.
- DEPTH, OUT_SIZE*OUT_SIZE, number of samples per frame. Derived; do not override.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, synchronous, active-low.
- ce  input  1  clock enable, active high. When low, all state is frozen.
- conv_dout  input  N  sample from the conv unit.
- conv_dout_vld  input  1  sample valid. Each cycle it is high with ce high counts as one sample.
- conv_dout_end  input  1  conv operation end flag. Level signal, high while the conv unit is idle.
- rd_start  input  1  request to begin draining a full frame. Single-cycle pulse or level.
- rd_ready  input  1  downstream ready.
- rd_dout  output  N  read stream data, registered.
- rd_vld  output  1  read stream valid.
- rd_last  output  1  high with the final sample of the frame.
- full  output  1  a complete frame is held and not yet drained.
- done  output  1  one-cycle pulse after the last sample is accepted.
- err  output  1  sticky error: overflow or short frame.

Behaviour:
- Single clock. Reset is synchronous, active-low: rst_n low at a clk edge forces state IDLE, wr_cnt=0, rd_cnt=0, rd_vld=0, rd_last=0, rd_dout=0, full=0, done=0, err=0.
- Reset takes priority over ce. Buffer contents are not cleared.
- Reset mid-FILL or mid-DRAIN abandons the frame; no done pulse.
- ce low: no state, counter, buffer or output change. Outputs hold their values.
- States: IDLE, FILL, FULL, DRAIN.
- IDLE:
  - conv_dout_vld=1 writes buf[0], sets wr_cnt=1 and moves to FILL.
  - rd_start is ignored.
- FILL:
  - conv_dout_vld=1 writes buf[wr_cnt] and increments wr_cnt.
  - The write that makes wr_cnt=DEPTH moves to FULL; full=1 from the next cycle.
  - A rising edge of conv_dout_end (0 then 1 on consecutive enabled cycles) with wr_cnt<DEPTH is a short frame: err=1, wr_cnt=0, go to IDLE.
  - rd_start is ignored.
- FULL:
  - conv_dout_vld=1 sets err=1; the sample is dropped and the buffer is unchanged.
  - rd_start=1 moves to DRAIN and presents buf[0] on the next cycle: rd_vld=1, rd_cnt=0. Latency is 1 cycle from rd_start to rd_vld.
- DRAIN:
  - rd_dout = buf[rd_cnt]. rd_dout, rd_vld and rd_last are held stable while rd_vld=1 and rd_ready=0.
  - Transfer occurs on a cycle with rd_vld=1 and rd_ready=1. Each transfer increments rd_cnt and presents the next sample on the following cycle, with no bubble, so throughput is 1 sample per cycle when rd_ready stays high.
  - rd_last=1 exactly when rd_cnt=DEPTH-1.
  - The transfer with rd_last=1 causes, on the next cycle: rd_vld=0, rd_last=0, full=0, done=1 for one cycle, wr_cnt=0, state IDLE.
  - conv_dout_vld=1 during DRAIN sets err=1; the sample is dropped.
- Cycle after a drain: a conv_dout_vld in the first cycle of IDLE (same cycle done=1) is accepted as sample 0 of the next frame.
- err clears only on reset.
- Buffer:
  - DEPTH x N registers or inferred RAM with a synchronous write port.
  - The read path must meet the 1-cycle rd_vld latency. The output register is loaded from buf[rd_cnt+1] on transfer.
- Widths:
  - wr_cnt and rd_cnt are clog2(DEPTH+1) bits.
  - Data passes through unmodified; no arithmetic on samples.

Test Plan (OUT_SIZE=4, N=8):
- Basic frame:
  - Stimulus: reset, then 16 conv_dout_vld pulses with values 1..16, gaps of 0-3 cycles; then rd_start with rd_ready=1.
  - Response: full=1 after the 16th write; rd_vld one cycle after rd_start; rd_dout 1..16 on consecutive cycles; rd_last with 16; done pulse the next cycle; full=0; err=0.
- Backpressure:
  - Stimulus: same frame; during drain, toggle rd_ready pseudo-randomly.
  - Response: every sample 1..16 delivered exactly once, in order; rd_dout stable while rd_ready=0.
- Overflow:
  - Stimulus: 17 vld pulses with values 1..17 before rd_start.
  - Response: err=1 after the 17th; drain yields 1..16 only.
- Short frame:
  - Stimulus: 10 samples, then conv_dout_end goes 0 then 1.
  - Response: err=1, full stays 0; state IDLE (rd_start produces no rd_vld). The next full frame of 16 samples still captures and drains correctly.
- ce freeze:
  - Stimulus: ce=0 for 5 cycles mid-FILL and mid-DRAIN with vld and rd_ready high.
  - Response: no samples written or transferred during ce=0; output sequence unchanged.
- Reset mid-drain:
  - Stimulus: rst_n=0 for one clock after the 6th transfer.
  - Response: next cycle rd_vld=0, full=0, err=0, no done. A fresh frame of values 101..116 drains as 101..116.
